// File: rtl/sr_ctrl_fsm.sv
// ============================================================================
// sr_ctrl_fsm
// ----------------------------------------------------------------------------
// Purpose:
//   Multi-cycle controller for the 16-bit register-file/ALU datapath
//   (regfile 8x16 -> A/B regs -> shifter -> ALU -> C reg, with Z/N/V status).
//   It accepts a decoded instruction class over a start/wait handshake,
//   latches it, and then walks the datapath through its load, select and
//   write strobes one state at a time.
//
// Ports:
//   clk      in   1       rising-edge clock
//   reset    in   1       synchronous, active-high reset
//   s        in   1       start; only looked at while waiting
//   opcode   in   3       instruction opcode (110 move class, 101 ALU class)
//   op       in   2       sub-op (ALU class: 00 ADD, 01 CMP, 10 AND, 11 MVN)
//   w        out  1       high only while waiting for a new instruction
//   nsel     out  NSEL_W  one-hot regfile select (Rn=001, Rd=010, Rm=100)
//   vsel     out  VSEL_W  writeback source (00 C reg, 10 sign-extended imm8)
//   write    out  1       regfile write enable
//   loada    out  1       A register load
//   loadb    out  1       B register load
//   loadc    out  1       C register load
//   loads    out  1       status register load
//   asel     out  1       1 = force ALU A operand to zero
//   bsel     out  1       B operand select, always the shifted B (0)
//   alu_op   out  2       ALU operation code
//   illegal  out  1       sticky unsupported-encoding flag
//                         (present only when SR_CTRL_ILLEGAL_TRAP_EN is defined)
//
// Build option:
//   SR_CTRL_ILLEGAL_TRAP_EN - adds the 'illegal' output. Without it, an
//   unsupported encoding simply falls back from DECODE to WAIT as a NOP.
// ============================================================================
module sr_ctrl_fsm #(
   parameter int NSEL_W = 3,
   parameter int VSEL_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   output logic              w,
   output logic [NSEL_W-1:0] nsel,
   output logic [VSEL_W-1:0] vsel,
   output logic              write,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
   output logic [1:0]        alu_op,
   output logic              illegal
`else
   output logic [1:0]        alu_op
`endif
);

   // Register-select codes as seen by the register file.
   localparam logic [NSEL_W-1:0] NSEL_NONE = '0;
   localparam logic [NSEL_W-1:0] NSEL_RN   = NSEL_W'(1);
   localparam logic [NSEL_W-1:0] NSEL_RD   = NSEL_W'(2);
   localparam logic [NSEL_W-1:0] NSEL_RM   = NSEL_W'(4);

   // Writeback mux codes.
   localparam logic [VSEL_W-1:0] VSEL_CREG = '0;
   localparam logic [VSEL_W-1:0] VSEL_IMM  = VSEL_W'(2);

   // Instruction encodings recognised by the decoder.
   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_EXEC,
      S_WRITE_REG
   } state_t;

   state_t      state;
   state_t      nextState;

   logic [2:0]  opcodeReg;
   logic [1:0]  opReg;

   logic        accept;
   logic        isMovImm;
   logic        isMovReg;
   logic        isMvn;
   logic        isCmp;
   logic        isTwoOperand;
   logic        isLegal;

   logic        writeRaw;
   logic        loadaRaw;
   logic        loadbRaw;
   logic        loadcRaw;
   logic        loadsRaw;

   // An instruction is taken only from WAIT; s is meaningless elsewhere.
   assign accept = (state == S_WAIT) && s;

   // State register. Reset is synchronous, so an in-flight instruction is
   // abandoned at the next edge and the controller simply lands in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
      end else begin
         state <= nextState;
      end
   end

   // The opcode/op inputs are only guaranteed stable up to the accept edge,
   // so every later decision is made from these captured copies.
   always_ff @(posedge clk) begin
      if (reset) begin
         opcodeReg <= '0;
         opReg     <= '0;
      end else if (accept) begin
         opcodeReg <= opcode;
         opReg     <= op;
      end
   end

   // Instruction classification from the captured encoding. The two-operand
   // group (ADD/CMP/AND) is the only one that needs the A register; MOV reg
   // and MVN only read Rm into B.
   always_comb begin
      isMovImm     = (opcodeReg == OPC_MOV) && (opReg == OP_MOVI);
      isMovReg     = (opcodeReg == OPC_MOV) && (opReg == OP_MOVR);
      isMvn        = (opcodeReg == OPC_ALU) && (opReg == OP_MVN);
      isCmp        = (opcodeReg == OPC_ALU) && (opReg == OP_CMP);
      isTwoOperand = (opcodeReg == OPC_ALU) &&
                     ((opReg == OP_ADD) || (opReg == OP_CMP) || (opReg == OP_AND));
      isLegal      = isMovImm || isMovReg || isMvn || isTwoOperand;
   end

   // Next-state logic. CMP only updates status, so it skips the writeback
   // state and returns straight to WAIT from EXEC.
   always_comb begin
      nextState = state;
      case (state)
         S_WAIT: begin
            if (s) begin
               nextState = S_DECODE;
            end
         end
         S_DECODE: begin
            if (isMovImm) begin
               nextState = S_WRITE_IMM;
            end else if (isMovReg || isMvn) begin
               nextState = S_GET_B;
            end else if (isTwoOperand) begin
               nextState = S_GET_A;
            end else begin
               nextState = S_WAIT;
            end
         end
         S_WRITE_IMM: nextState = S_WAIT;
         S_GET_A:     nextState = S_GET_B;
         S_GET_B:     nextState = S_EXEC;
         S_EXEC: begin
            if (isCmp) begin
               nextState = S_WAIT;
            end else begin
               nextState = S_WRITE_REG;
            end
         end
         S_WRITE_REG: nextState = S_WAIT;
         default:     nextState = S_WAIT;
      endcase
   end

   // Moore output decode. Everything depends only on the current state and
   // the captured instruction, never on the live inputs. The load/write
   // strobes are produced here in raw form and gated against reset below.
   always_comb begin
      w        = 1'b0;
      nsel     = NSEL_NONE;
      vsel     = VSEL_CREG;
      writeRaw = 1'b0;
      loadaRaw = 1'b0;
      loadbRaw = 1'b0;
      loadcRaw = 1'b0;
      loadsRaw = 1'b0;
      asel     = 1'b0;
      alu_op   = 2'b00;
      case (state)
         S_WAIT: begin
            w = 1'b1;
         end
         S_DECODE: begin
         end
         S_WRITE_IMM: begin
            nsel     = NSEL_RN;
            vsel     = VSEL_IMM;
            writeRaw = 1'b1;
         end
         S_GET_A: begin
            nsel     = NSEL_RN;
            loadaRaw = 1'b1;
         end
         S_GET_B: begin
            nsel     = NSEL_RM;
            loadbRaw = 1'b1;
         end
         S_EXEC: begin
            // MOV reg passes B through the adder with A forced to zero.
            // ALU-class ops use their sub-op directly as the ALU code, which
            // also covers MVN (11). Status is loaded by every ALU-class op;
            // CMP keeps the C register untouched since nothing is written.
            if (isMovReg) begin
               asel     = 1'b1;
               alu_op   = 2'b00;
               loadcRaw = 1'b1;
            end else begin
               asel     = 1'b0;
               alu_op   = opReg;
               loadcRaw = !isCmp;
               loadsRaw = 1'b1;
            end
         end
         S_WRITE_REG: begin
            nsel     = NSEL_RD;
            vsel     = VSEL_CREG;
            writeRaw = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Reset only takes effect at the next edge, so during the reset cycle the
   // state may still be mid-instruction. The datapath-modifying strobes are
   // forced low combinationally so that cycle cannot corrupt any register.
   assign write = writeRaw & ~reset;
   assign loada = loadaRaw & ~reset;
   assign loadb = loadbRaw & ~reset;
   assign loadc = loadcRaw & ~reset;
   assign loads = loadsRaw & ~reset;

   // The shifter output is always the B operand in this instruction set.
   assign bsel = 1'b0;

`ifdef SR_CTRL_ILLEGAL_TRAP_EN
   logic illegalReg;

   // Sticky trap flag: raised when DECODE gives up on an encoding and stays
   // up until the software side issues another instruction or resets.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegalReg <= 1'b0;
      end else if (accept) begin
         illegalReg <= 1'b0;
      end else if ((state == S_DECODE) && !isLegal) begin
         illegalReg <= 1'b1;
      end
   end

   assign illegal = illegalReg;
`endif

endmodule

// File: tb/tb_sr_ctrl_fsm.sv
// ============================================================================
// tb_sr_ctrl_fsm
// ----------------------------------------------------------------------------
// Self-checking bench for sr_ctrl_fsm. A behavioural model turns each
// instruction into the list of per-cycle output vectors the controller must
// show between the accept edge and its return to WAIT; random and directed
// instructions are then compared cycle by cycle against that list.
// Build option SR_CTRL_ILLEGAL_TRAP_EN also enables the illegal-flag checks.
// ============================================================================
module tb_sr_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       write;
   logic       loada;
   logic       loadb;
   logic       loadc;
   logic       loads;
   logic       asel;
   logic       bsel;
   logic [1:0] alu_op;
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
   bit         expIllegal = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       w;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       write;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] aluOp;
   } outVec_t;

   outVec_t expQ[$];

   sr_ctrl_fsm #(.NSEL_W(3), .VSEL_W(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .s       (s),
      .opcode  (opcode),
      .op      (op),
      .w       (w),
      .nsel    (nsel),
      .vsel    (vsel),
      .write   (write),
      .loada   (loada),
      .loadb   (loadb),
      .loadc   (loadc),
      .loads   (loads),
      .asel    (asel),
      .bsel    (bsel),
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
      .alu_op  (alu_op),
      .illegal (illegal)
`else
      .alu_op  (alu_op)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic outVec_t mkVec(input logic vw, input logic [2:0] vn,
                                     input logic [1:0] vv, input logic wr,
                                     input logic la, input logic lb,
                                     input logic lc, input logic ls,
                                     input logic as, input logic [1:0] alu);
      outVec_t v;
      v.w = vw; v.nsel = vn; v.vsel = vv; v.write = wr;
      v.loada = la; v.loadb = lb; v.loadc = lc; v.loads = ls;
      v.asel = as; v.bsel = 1'b0; v.aluOp = alu;
      return v;
   endfunction

   function automatic outVec_t observed();
      outVec_t v;
      v.w = w; v.nsel = nsel; v.vsel = vsel; v.write = write;
      v.loada = loada; v.loadb = loadb; v.loadc = loadc; v.loads = loads;
      v.asel = asel; v.bsel = bsel; v.aluOp = alu_op;
      return v;
   endfunction

   function automatic bit isLegalEnc(input logic [2:0] opc, input logic [1:0] o);
      return (opc == 3'b110 && (o == 2'b10 || o == 2'b00)) || (opc == 3'b101);
   endfunction

   function automatic bit writesReg(input logic [2:0] opc, input logic [1:0] o);
      return isLegalEnc(opc, o) && !(opc == 3'b101 && o == 2'b01);
   endfunction

   // Reference model: the cycles an instruction occupies after acceptance,
   // described as the datapath actions each step must request.
   function automatic void buildTrace(input logic [2:0] opc, input logic [1:0] o);
      outVec_t idleStep;
      idleStep = mkVec(1'b0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      expQ.delete();
      expQ.push_back(idleStep);
      if (opc == 3'b110 && o == 2'b10) begin
         expQ.push_back(mkVec(0, 3'b001, 2'b10, 1, 0, 0, 0, 0, 0, 2'b00));
      end else if (opc == 3'b110 && o == 2'b00) begin
         expQ.push_back(mkVec(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00));
         expQ.push_back(mkVec(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00));
         expQ.push_back(mkVec(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00));
      end else if (opc == 3'b101) begin
         if (o != 2'b11) begin
            expQ.push_back(mkVec(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00));
         end
         expQ.push_back(mkVec(0, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00));
         expQ.push_back(mkVec(0, 3'b000, 2'b00, 0, 0, 0, (o != 2'b01), 1, 0, o));
         if (o != 2'b01) begin
            expQ.push_back(mkVec(0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00));
         end
      end
   endfunction

   // Advance one clock and settle just past the edge before sampling.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Run one instruction: optional idle gap, accept, then compare every
   // cycle until the controller is back in WAIT.
   task automatic runInstr(input logic [2:0] opc, input logic [1:0] o,
                           input bit holdS, input int gap, input string tag);
      outVec_t idleVec;
      outVec_t obs;
      int      writes;
      idleVec = mkVec(1'b1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      for (int g = 0; g < gap; g++) begin
         s      = 1'b0;
         opcode = 3'($urandom_range(0, 7));
         op     = 2'($urandom_range(0, 3));
         stepCycle();
         obs = observed();
         checks++;
         if (obs !== idleVec) begin
            failures++;
            $display("[TB] FAIL %s gap%0d: observed=%h expected=%h", tag, g, obs, idleVec);
         end
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
         checks++;
         if (illegal !== expIllegal) begin
            failures++;
            $display("[TB] FAIL %s sticky illegal: observed=%b expected=%b", tag, illegal, expIllegal);
         end
`endif
      end
      buildTrace(opc, o);
      s      = 1'b1;
      opcode = opc;
      op     = o;
      writes = 0;
      stepCycle();
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
      expIllegal = 1'b0;
`endif
      for (int k = 0; k < expQ.size(); k++) begin
         obs = observed();
         checks++;
         if (obs !== expQ[k]) begin
            failures++;
            $display("[TB] FAIL %s cycle%0d: observed=%h expected=%h", tag, k + 1, obs, expQ[k]);
         end
         if (obs.write === 1'b1) begin
            writes++;
         end
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
         checks++;
         if (illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s illegal in flight: observed=%b expected=0", tag, illegal);
         end
`endif
         s      = holdS ? 1'b1 : 1'($urandom_range(0, 1));
         opcode = 3'($urandom_range(0, 7));
         op     = 2'($urandom_range(0, 3));
         stepCycle();
      end
      obs = observed();
      checks++;
      if (obs !== idleVec) begin
         failures++;
         $display("[TB] FAIL %s done: observed=%h expected=%h", tag, obs, idleVec);
      end
      checks++;
      if (writes != int'(writesReg(opc, o))) begin
         failures++;
         $display("[TB] FAIL %s write count: observed=%0d expected=%0d", tag, writes, int'(writesReg(opc, o)));
      end
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
      expIllegal = !isLegalEnc(opc, o);
      checks++;
      if (illegal !== expIllegal) begin
         failures++;
         $display("[TB] FAIL %s illegal: observed=%b expected=%b", tag, illegal, expIllegal);
      end
`endif
      s = holdS ? 1'b1 : 1'b0;
   endtask

   // Reset held with a start request pending must keep the controller idle.
   task automatic test_reset();
      outVec_t idleVec;
      outVec_t obs;
      idleVec = mkVec(1'b1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      reset  = 1'b1;
      s      = 1'b1;
      opcode = 3'b101;
      op     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         stepCycle();
         obs = observed();
         checks++;
         if (obs !== idleVec) begin
            failures++;
            $display("[TB] FAIL reset_hold%0d: observed=%h expected=%h", i, obs, idleVec);
         end
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
         checks++;
         if (illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset illegal: observed=%b expected=0", illegal);
         end
`endif
      end
      s     = 1'b0;
      reset = 1'b0;
      stepCycle();
      obs = observed();
      checks++;
      if (obs !== idleVec) begin
         failures++;
         $display("[TB] FAIL reset_release: observed=%h expected=%h", obs, idleVec);
      end
   endtask

   task automatic test_directed();
      runInstr(3'b110, 2'b10, 1'b0, 0, "mov_imm");
      runInstr(3'b101, 2'b00, 1'b0, 1, "add");
      runInstr(3'b101, 2'b01, 1'b0, 1, "cmp");
      runInstr(3'b101, 2'b10, 1'b0, 0, "and");
      runInstr(3'b110, 2'b00, 1'b0, 2, "mov_reg");
      runInstr(3'b101, 2'b11, 1'b0, 0, "mvn");
      runInstr(3'b111, 2'b00, 1'b0, 1, "illegal_111");
      runInstr(3'b110, 2'b01, 1'b0, 2, "illegal_110_01");
      runInstr(3'b110, 2'b10, 1'b0, 0, "mov_after_illegal");
   endtask

   // s held high throughout: each instruction starts on the first WAIT cycle.
   task automatic test_back_to_back();
      logic [4:0] legalTbl [6];
      logic [4:0] pick;
      legalTbl = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11};
      for (int i = 0; i < 8; i++) begin
         pick = legalTbl[$urandom_range(0, 5)];
         runInstr(pick[4:2], pick[1:0], 1'b1, 0, "back_to_back");
      end
      s = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0] opc;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    opc = 3'b101;
            2:       opc = 3'b110;
            default: opc = 3'($urandom_range(0, 7));
         endcase
         runInstr(opc, 2'($urandom_range(0, 3)), 1'b0, $urandom_range(0, 2), "random");
      end
   endtask

   // Reset arriving during EXEC must suppress that cycle's loads and abort
   // the writeback entirely.
   task automatic test_reset_mid_op();
      outVec_t idleVec;
      outVec_t execVec;
      outVec_t obs;
      int      writes;
      idleVec = mkVec(1'b1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      execVec = mkVec(1'b0, 3'b000, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00);
      s      = 1'b1;
      opcode = 3'b101;
      op     = 2'b00;
      stepCycle();
      s = 1'b0;
      repeat (3) stepCycle();
      obs = observed();
      checks++;
      if (obs !== execVec) begin
         failures++;
         $display("[TB] FAIL reset_mid exec reached: observed=%h expected=%h", obs, execVec);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({write, loada, loadb, loadc, loads} !== 5'b00000) begin
         failures++;
         $display("[TB] FAIL reset_mid gating: observed=%b expected=00000",
                  {write, loada, loadb, loadc, loads});
      end
      stepCycle();
      reset = 1'b0;
`ifdef SR_CTRL_ILLEGAL_TRAP_EN
      expIllegal = 1'b0;
`endif
      writes = 0;
      for (int i = 0; i < 3; i++) begin
         obs = observed();
         writes += int'(obs.write === 1'b1);
         checks++;
         if (obs !== idleVec) begin
            failures++;
            $display("[TB] FAIL reset_mid after%0d: observed=%h expected=%h", i, obs, idleVec);
         end
         stepCycle();
      end
      checks++;
      if (writes != 0) begin
         failures++;
         $display("[TB] FAIL reset_mid writes: observed=%0d expected=0", writes);
      end
      runInstr(3'b111, 2'b11, 1'b0, 0, "post_reset_illegal");
      runInstr(3'b101, 2'b00, 1'b0, 2, "post_reset_add");
   endtask

   initial begin
      s      = 1'b0;
      opcode = 3'b000;
      op     = 2'b00;
      reset  = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
